// File: rtl/imem_stream_loader.sv
// Boot loader: streams instruction words into byte-wide imem,
// holding the core in reset until the programmed count is loaded.
module imem_stream_loader #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          BIG_ENDIAN  = 1'b0,
  localparam int unsigned BPW    = XLEN / 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS * BPW),
  localparam int unsigned CNT_W  = $clog2(DEPTH_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  input  logic [XLEN-1:0]   s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   checksum
);

  localparam int unsigned BI_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0]  MAX_W  = CNT_W'(DEPTH_WORDS);
  localparam logic [BI_W-1:0]   LAST_B = BI_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(BPW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_word_idx;
  logic [BI_W-1:0]   r_byte_idx;
  logic [XLEN-1:0]   r_word;
  logic [ADDR_W-1:0] r_base;
  logic              w_last_byte;
  logic              w_last_word;

  // Byte i in stream order; BE walks down from the MSB.
  function automatic logic [7:0] f_byte(
    input logic [XLEN-1:0] w,
    input logic [BI_W-1:0] i
  );
    int unsigned     k;
    logic [XLEN-1:0] t;
    k = BIG_ENDIAN ? (BPW - 1 - int'(i)) : int'(i);
    t = w >> (8 * k);
    return t[7:0];
  endfunction

  assign s_ready     = (r_state == S_RECV);
  assign w_last_byte = (r_byte_idx == LAST_B);
  assign w_last_word = (r_word_idx == r_count - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_base     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // Zero-length loads raise done one cycle after entry.
          if (r_state == S_DONE) begin
            done    <= 1'b1;
            cpu_rst <= 1'b1;
          end
          if (start) begin
            done    <= 1'b0;
            cpu_rst <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            if (word_count == '0) begin
              checksum <= '0;
              r_state  <= S_DONE;
            end else if (word_count > MAX_W) begin
              err     <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_count    <= word_count;
              checksum   <= '0;
              r_word_idx <= '0;
              r_base     <= BASE;
              busy       <= 1'b1;
              r_state    <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (s_valid) begin
            r_word     <= s_data;
            checksum   <= checksum + s_data;
            r_byte_idx <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= r_base;
            mem_wdata  <= f_byte(s_data, '0);
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_last_byte) begin
            if (w_last_word) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_rst <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_word_idx <= r_word_idx + CNT_W'(1);
              r_base     <= r_base + STEP;
              r_state    <= S_RECV;
            end
          end else begin
            r_byte_idx <= r_byte_idx + BI_W'(1);
            mem_we     <= 1'b1;
            mem_addr   <= mem_addr + ADDR_W'(1);
            mem_wdata  <= f_byte(r_word, r_byte_idx + BI_W'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench: stimulus queues expected byte writes,
// a negedge monitor pops and compares them.
module tb_imem_stream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        a_start = 0, a_sv = 0;
  logic [7:0]  a_wc = 0;
  logic [31:0] a_sd = 0;
  logic        a_sr, a_we, a_cr, a_busy, a_done, a_err;
  logic [8:0]  a_addr;
  logic [7:0]  a_wd;
  logic [31:0] a_cs;

  logic        b_start = 0, b_sv = 0;
  logic [7:0]  b_wc = 0;
  logic [31:0] b_sd = 0;
  logic        b_sr, b_we, b_cr, b_busy, b_done, b_err;
  logic [8:0]  b_addr;
  logic [7:0]  b_wd;
  logic [31:0] b_cs;

  logic [16:0] qa[$];
  logic [16:0] qb[$];

  imem_stream_loader u_le (
    .clk(clk), .rst(rst), .start(a_start), .word_count(a_wc),
    .s_valid(a_sv), .s_data(a_sd), .s_ready(a_sr),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
    .cpu_rst(a_cr), .busy(a_busy), .done(a_done), .err(a_err),
    .checksum(a_cs)
  );

  imem_stream_loader #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .start(b_start), .word_count(b_wc),
    .s_valid(b_sv), .s_data(b_sd), .s_ready(b_sr),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .cpu_rst(b_cr), .busy(b_busy), .done(b_done), .err(b_err),
    .checksum(b_cs)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (a_we === 1'b1) begin
      if (qa.size() == 0)
        chk("a_wr_expected", 64'(qa.size() != 0), 64'd1);
      else
        chk("a_wr", 64'({a_addr, a_wd}), 64'(qa.pop_front()));
      chk("a_sready_in_write", 64'(a_sr), 64'd0);
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0)
        chk("b_wr_expected", 64'(qb.size() != 0), 64'd1);
      else
        chk("b_wr", 64'({b_addr, b_wd}), 64'(qb.pop_front()));
      chk("b_sready_in_write", 64'(b_sr), 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_le(input int base, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      qa.push_back({9'(base + k), t[7:0]});
      t = t >> 8;
    end
  endtask

  task automatic start_a(input logic [7:0] wc);
    a_wc    = wc;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d, input int gap);
    int n;
    int g;
    bit ok;
    n = 0; g = gap; ok = 0;
    a_sd = d;
    a_sv = 1'b0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      n++;
      if (a_sr) begin
        if (g > 0) g--;
        else begin
          a_sv = 1'b1;
          tick();
          a_sv = 1'b0;
          ok = 1;
        end
      end
    end
    chk("a_send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_a_done(input int bound);
    int n;
    n = 0;
    while (a_done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_seen", 64'(a_done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    #1 rst = 1'b0;
    #14;
    chk("a_reset_outs", 64'({a_sr, a_we, a_addr, a_wd, a_cr,
                             a_busy, a_done, a_err}), 64'd0);
    chk("a_reset_cs", 64'(a_cs), 64'd0);
    chk("b_reset_outs", 64'({b_sr, b_we, b_addr, b_wd, b_cr,
                             b_busy, b_done, b_err}), 64'd0);
    #7 rst = 1'b1;
    tick();

    // two LE words, timing from start to done
    qa.push_back({9'd0, 8'h93}); qa.push_back({9'd1, 8'h00});
    qa.push_back({9'd2, 8'h50}); qa.push_back({9'd3, 8'h00});
    qa.push_back({9'd4, 8'h13}); qa.push_back({9'd5, 8'h01});
    qa.push_back({9'd6, 8'h10}); qa.push_back({9'd7, 8'h00});
    c0 = cyc;
    start_a(8'd2);
    send_a(32'h00500093, 0);
    send_a(32'h00100113, 0);
    wait_a_done(20);
    chk("a_latency", 64'(cyc - c0), 64'd11);
    chk("a_cpu_rst_done", 64'(a_cr), 64'd1);
    chk("a_busy_done", 64'(a_busy), 64'd0);
    chk("a_cs_2w", 64'(a_cs), 64'h006001A6);
    chk("a_q_empty_1", 64'(qa.size()), 64'd0);

    // big-endian instance
    qb.push_back({9'd0, 8'h11}); qb.push_back({9'd1, 8'h22});
    qb.push_back({9'd2, 8'h33}); qb.push_back({9'd3, 8'h44});
    b_wc = 8'd1; b_start = 1'b1; tick(); b_start = 1'b0;
    b_sd = 32'h11223344;
    @(negedge clk);
    chk("b_ready_recv", 64'(b_sr), 64'd1);
    b_sv = 1'b1; tick(); b_sv = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_cpu_rst", 64'(b_cr), 64'd1);
    chk("b_cs", 64'(b_cs), 64'h11223344);
    chk("b_q_empty", 64'(qb.size()), 64'd0);

    // backpressure gaps plus a start pulse during WRITE
    push_le(0, 32'hDEADBEEF);
    push_le(4, 32'h01234567);
    push_le(8, 32'h89ABCDEF);
    start_a(8'd3);
    @(negedge clk);
    chk("a_restart_cpu_rst", 64'(a_cr), 64'd0);
    chk("a_restart_done", 64'(a_done), 64'd0);
    send_a(32'hDEADBEEF, 0);
    a_wc = 8'd0; a_start = 1'b1; tick(); a_start = 1'b0;
    @(negedge clk);
    chk("a_start_ignored_busy", 64'(a_busy), 64'd1);
    chk("a_start_ignored_done", 64'(a_done), 64'd0);
    send_a(32'h01234567, 2);
    send_a(32'h89ABCDEF, 2);
    wait_a_done(30);
    chk("a_cs_3w", 64'(a_cs), 64'h697CD245);
    chk("a_q_empty_2", 64'(qa.size()), 64'd0);

    // oversize count -> error, then recover
    start_a(8'd129);
    @(negedge clk);
    chk("a_err_set", 64'(a_err), 64'd1);
    chk("a_err_cpu_rst", 64'(a_cr), 64'd0);
    chk("a_err_ready", 64'(a_sr), 64'd0);
    repeat (5) tick();
    chk("a_err_hold", 64'(a_err), 64'd1);
    push_le(0, 32'hCAFEF00D);
    start_a(8'd1);
    @(negedge clk);
    chk("a_err_clear", 64'(a_err), 64'd0);
    send_a(32'hCAFEF00D, 0);
    wait_a_done(20);
    chk("a_cs_recover", 64'(a_cs), 64'hCAFEF00D);

    // zero-length load
    start_a(8'd0);
    wait_a_done(3);
    chk("a_zero_cs", 64'(a_cs), 64'd0);
    chk("a_zero_cpu_rst", 64'(a_cr), 64'd1);

    // async reset during WRITE of word 1
    push_le(0, 32'hA0B0C0D0);
    qa.push_back({9'd4, 8'h04});
    start_a(8'd2);
    send_a(32'hA0B0C0D0, 0);
    send_a(32'h01020304, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("a_async_outs", 64'({a_sr, a_we, a_addr, a_wd, a_cr,
                             a_busy, a_done, a_err}), 64'd0);
    chk("a_async_cs", 64'(a_cs), 64'd0);
    chk("a_q_empty_rst", 64'(qa.size()), 64'd0);
    #20 rst = 1'b1;
    tick();
    push_le(0, 32'h12345678);
    push_le(4, 32'h9ABCDEF0);
    start_a(8'd2);
    send_a(32'h12345678, 0);
    send_a(32'h9ABCDEF0, 0);
    wait_a_done(20);
    chk("a_cs_after_rst", 64'(a_cs), 64'hACF13568);

    // restart from DONE releases core reset only after reload
    push_le(0, 32'h0000006F);
    start_a(8'd1);
    @(negedge clk);
    chk("a_done_restart_cpu_rst", 64'(a_cr), 64'd0);
    send_a(32'h0000006F, 0);
    wait_a_done(20);
    chk("a_cs_final", 64'(a_cs), 64'h0000006F);

    repeat (3) tick();
    chk("a_q_empty_end", 64'(qa.size()), 64'd0);
    chk("b_q_empty_end", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
